// File: rtl/framebuffer_arbiter.sv
// framebuffer_arbiter
//  Owns the 1024x8 OLED framebuffer (128x64, 1bpp, page-major) and time-shares
//  its single synchronous RAM port between the SPI screen driver (read-only,
//  never stalled) and one drawing client (byte writes, pixel read-modify-write,
//  full-screen clear). Even cycles (phase 0) belong to the screen and odd cycles
//  (phase 1) belong to the writer.
//
//  Ports
//   clk_i       system clock
//   rst_n_i     asynchronous active-low reset
//   scr_addr_i  screen driver byte address
//   scr_data_o  registered framebuffer byte for scr_addr_i
//   wr_valid_i  drawing request valid
//   wr_ready_o  request accepted when wr_valid_i & wr_ready_o at a rising edge
//   wr_mode_i   0 = byte write, 1 = pixel write
//   wr_addr_i   byte address; for pixels {y[5:3], x[6:0]}
//   wr_bit_i    pixel bit index (y[2:0]); ignored in byte mode
//   wr_data_i   byte data; pixel value on bit 0 in pixel mode
//   clear_i     one-cycle pulse requesting a fill with CLEAR_VALUE
//   busy_o      clear or pixel operation pending or in progress
//   done_o      one-cycle pulse after the last clear write
module framebuffer_arbiter #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [7:0]  CLEAR_VALUE = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [9:0] scr_addr_i,
  output logic [7:0] scr_data_o,
  input  logic       wr_valid_i,
  output logic       wr_ready_o,
  input  logic       wr_mode_i,
  input  logic [9:0] wr_addr_i,
  input  logic [2:0] wr_bit_i,
  input  logic [7:0] wr_data_i,
  input  logic       clear_i,
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic [1:0] {S_IDLE, S_PIX_CAP, S_PIX_WR, S_CLEAR} state_t;

  state_t     state_reg, state_next;
  logic       phase_reg;
  logic       clr_pending_reg, clr_pending_next;
  logic [9:0] clr_cnt_reg, clr_cnt_next;
  logic       done_reg, done_next;
  logic [9:0] pix_addr_reg, pix_addr_next;
  logic [2:0] pix_bit_reg, pix_bit_next;
  logic       pix_val_reg, pix_val_next;
  logic [7:0] rmw_reg, rmw_next;
  logic [7:0] scr_data_reg;

  // Single-port framebuffer with registered read
  logic [7:0] mem [DEPTH];
  logic [7:0] ram_q;
  logic       ram_en;
  logic       ram_we;
  logic [9:0] ram_addr;
  logic [7:0] ram_wdata;

  logic       accept;
  logic       clr_last;
  logic [7:0] pix_merged;

  assign clr_last = (clr_cnt_reg == 10'(DEPTH - 1));

  // Captured byte with the addressed pixel replaced
  for (genvar gi = 0; gi < 8; gi++) begin : g_merge
    assign pix_merged[gi] = (pix_bit_reg == 3'(gi)) ? pix_val_reg : rmw_reg[gi];
  end

  always_comb begin
    state_next       = state_reg;
    clr_pending_next = clr_pending_reg;
    clr_cnt_next     = clr_cnt_reg;
    done_next        = 1'b0;
    pix_addr_next    = pix_addr_reg;
    pix_bit_next     = pix_bit_reg;
    pix_val_next     = pix_val_reg;
    rmw_next         = rmw_reg;
    // Screen slot reads by default; writer slot only touches the RAM when needed
    ram_en           = ~phase_reg;
    ram_we           = 1'b0;
    ram_addr         = scr_addr_i;
    ram_wdata        = wr_data_i;
    wr_ready_o       = phase_reg & (state_reg == S_IDLE) & ~clr_pending_reg;
    accept           = wr_ready_o & wr_valid_i;

    // Re-raising while pending or clearing changes nothing
    if (clear_i) clr_pending_next = 1'b1;

    case (state_reg)
      S_IDLE: begin
        if (phase_reg) begin
          if (clr_pending_reg) begin
            state_next   = S_CLEAR;
            clr_cnt_next = '0;
          end else if (accept) begin
            ram_en   = 1'b1;
            ram_addr = wr_addr_i;
            if (wr_mode_i) begin
              // Read the target byte now; it lands in ram_q for PIX_CAP
              pix_addr_next = wr_addr_i;
              pix_bit_next  = wr_bit_i;
              pix_val_next  = wr_data_i[0];
              state_next    = S_PIX_CAP;
            end else begin
              ram_we    = 1'b1;
              ram_wdata = wr_data_i;
            end
          end
        end
      end
      S_PIX_CAP: begin
        // Screen read proceeds in this slot, so park the writer byte first
        rmw_next   = ram_q;
        state_next = S_PIX_WR;
      end
      S_PIX_WR: begin
        ram_en     = 1'b1;
        ram_we     = 1'b1;
        ram_addr   = pix_addr_reg;
        ram_wdata  = pix_merged;
        state_next = S_IDLE;
      end
      S_CLEAR: begin
        if (phase_reg) begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = clr_cnt_reg;
          ram_wdata = CLEAR_VALUE;
          if (clr_last) begin
            clr_cnt_next     = '0;
            clr_pending_next = 1'b0;
            done_next        = 1'b1;
            state_next       = S_IDLE;
          end else begin
            clr_cnt_next = clr_cnt_reg + 10'd1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg       <= S_IDLE;
      phase_reg       <= 1'b0;
      clr_pending_reg <= 1'b0;
      clr_cnt_reg     <= '0;
      done_reg        <= 1'b0;
      pix_addr_reg    <= '0;
      pix_bit_reg     <= '0;
      pix_val_reg     <= 1'b0;
      rmw_reg         <= '0;
      scr_data_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      phase_reg       <= ~phase_reg;
      clr_pending_reg <= clr_pending_next;
      clr_cnt_reg     <= clr_cnt_next;
      done_reg        <= done_next;
      pix_addr_reg    <= pix_addr_next;
      pix_bit_reg     <= pix_bit_next;
      pix_val_reg     <= pix_val_next;
      rmw_reg         <= rmw_next;
      // ram_q still holds the screen byte at the end of the writer slot
      if (phase_reg) scr_data_reg <= ram_q;
    end
  end

  // Contents are deliberately not reset
  always_ff @(posedge clk_i) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_q         <= mem[ram_addr];
    end
  end

  assign scr_data_o = scr_data_reg;
  assign busy_o     = clr_pending_reg | (state_reg != S_IDLE);
  assign done_o     = done_reg;

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Bench for framebuffer_arbiter: stimulus pushes expectations into a queue and
// a negedge monitor pops and compares them against the DUT outputs.
module tb_framebuffer_arbiter;

  localparam int DEPTH = 1024;
  localparam int SEL_SCR  = 0;
  localparam int SEL_RDY  = 1;
  localparam int SEL_BUSY = 2;
  localparam int SEL_DONE = 3;
  localparam int SEL_MEAS = 4;
  localparam int SEL_DCNT = 5;

  logic       clk_i;
  logic       rst_n_i;
  logic [9:0] scr_addr_i;
  logic [7:0] scr_data_o;
  logic       wr_valid_i;
  logic       wr_ready_o;
  logic       wr_mode_i;
  logic [9:0] wr_addr_i;
  logic [2:0] wr_bit_i;
  logic [7:0] wr_data_i;
  logic       clear_i;
  logic       busy_o;
  logic       done_o;

  framebuffer_arbiter #(.DEPTH(DEPTH), .CLEAR_VALUE(8'h00)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .scr_addr_i (scr_addr_i),
    .scr_data_o (scr_data_o),
    .wr_valid_i (wr_valid_i),
    .wr_ready_o (wr_ready_o),
    .wr_mode_i  (wr_mode_i),
    .wr_addr_i  (wr_addr_i),
    .wr_bit_i   (wr_bit_i),
    .wr_data_i  (wr_data_i),
    .clear_i    (clear_i),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
    logic [31:0] meas;
  } item_t;

  item_t exp_q[$];
  int    total    = 0;
  int    bad      = 0;
  int    done_cnt = 0;
  int    exp_done = 0;

  function automatic void expect_sig(input string name, input int sel,
                                     input logic [31:0] exp, input logic [31:0] meas);
    item_t it;
    it.name = name;
    it.sel  = sel;
    it.exp  = exp;
    it.meas = meas;
    exp_q.push_back(it);
  endfunction

  // Monitor: counts done pulses and resolves every queued expectation
  always @(negedge clk_i) begin : monitor
    item_t       it;
    logic [31:0] act;
    if (done_o === 1'b1) done_cnt++;
    while (exp_q.size() > 0) begin
      it = exp_q.pop_front();
      case (it.sel)
        SEL_SCR:  act = {24'd0, scr_data_o};
        SEL_RDY:  act = {31'd0, wr_ready_o};
        SEL_BUSY: act = {31'd0, busy_o};
        SEL_DONE: act = {31'd0, done_o};
        SEL_DCNT: act = done_cnt;
        default:  act = it.meas;
      endcase
      total++;
      if (act !== it.exp) begin
        bad++;
        $display("FAIL %s: got=%0h want=%0h", it.name, act, it.exp);
      end else begin
        $display("pass %s: %0h", it.name, act);
      end
    end
  end

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got=timeout want=event", name);
  endtask

  // Holds the current request until the DUT takes it; returns #1 after that edge
  task automatic wait_accept(input string name, output longint t_acc);
    bit ok;
    ok    = 1'b0;
    t_acc = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk_i);
      if (wr_ready_o) begin
        ok = 1'b1;
        @(posedge clk_i);
        t_acc = $time;
        #1;
      end
    end
    if (!ok) fail_now(name);
  endtask

  task automatic byte_write(input logic [9:0] a, input logic [7:0] d);
    longint t;
    wr_valid_i = 1'b1; wr_mode_i = 1'b0; wr_addr_i = a; wr_data_i = d;
    wait_accept("byte_accept", t);
    wr_valid_i = 1'b0;
  endtask

  task automatic fill_bytes(input logic [7:0] d);
    longint t;
    wr_valid_i = 1'b1; wr_mode_i = 1'b0; wr_data_i = d;
    for (int a = 0; a < DEPTH; a++) begin
      wr_addr_i = 10'(a);
      wait_accept("fill_accept", t);
    end
    wr_valid_i = 1'b0;
  endtask

  // Upper data bits carry junk: only bit 0 may matter in pixel mode
  task automatic pixel_op(input logic [9:0] a, input logic [2:0] b, input logic v,
                          input bit chk, input string tag);
    longint t;
    wr_valid_i = 1'b1; wr_mode_i = 1'b1; wr_addr_i = a; wr_bit_i = b;
    wr_data_i  = {7'b1010101, v};
    wait_accept({tag, "_accept"}, t);
    wr_valid_i = 1'b0;
    if (chk) begin
      expect_sig({tag, "_rdy_c1"},  SEL_RDY,  0, 0);
      expect_sig({tag, "_busy_c1"}, SEL_BUSY, 1, 0);
      @(posedge clk_i); #1;
      expect_sig({tag, "_rdy_c2"},  SEL_RDY,  0, 0);
      expect_sig({tag, "_busy_c2"}, SEL_BUSY, 1, 0);
      @(posedge clk_i); #1;
      expect_sig({tag, "_rdy_c3"},  SEL_RDY,  0, 0);
      expect_sig({tag, "_busy_c3"}, SEL_BUSY, 0, 0);
      @(posedge clk_i); #1;
      expect_sig({tag, "_rdy_c4"},  SEL_RDY,  1, 0);
    end
  endtask

  // Address change to settled data is at most 4 clocks
  task automatic read_check(input logic [9:0] a, input logic [7:0] d);
    scr_addr_i = a;
    repeat (4) @(posedge clk_i);
    #1;
    expect_sig($sformatf("rd_%03h", a), SEL_SCR, {24'd0, d}, 0);
  endtask

  // Leaves the bench #1 into a screen-slot cycle
  task automatic align_phase0();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk_i);
      if (wr_ready_o) ok = 1'b1;
    end
    if (!ok) fail_now("align");
    @(posedge clk_i); #1;
  endtask

  // Clear started in a screen slot: one hand-off writer slot, then 1024 write
  // slots, so busy stays high for 1 + 2*1024 = 2049 cycles
  task automatic clear_and_measure(input string tag);
    int n_busy;
    int n_rdy;
    bit fin;
    logic done_at_end;
    align_phase0();
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    exp_done++;
    n_busy = 0; n_rdy = 0; fin = 1'b0; done_at_end = 1'b0;
    for (int i = 0; i < 2200 && !fin; i++) begin
      @(negedge clk_i);
      if (busy_o) begin
        n_busy++;
        if (wr_ready_o) n_rdy++;
      end else begin
        fin = 1'b1;
        done_at_end = done_o;
      end
    end
    if (!fin) fail_now({tag, "_busy_end"});
    expect_sig({tag, "_busy_len"},  SEL_MEAS, 2049, n_busy);
    expect_sig({tag, "_rdy_high"},  SEL_MEAS, 0, n_rdy);
    expect_sig({tag, "_done_last"}, SEL_MEAS, 1, {31'd0, done_at_end});
    expect_sig({tag, "_done_cnt"},  SEL_DCNT, exp_done, 0);
  endtask

  longint t_acc;
  longint t_prev;

  initial begin
    rst_n_i = 1'b0; scr_addr_i = '0; wr_valid_i = 1'b0; wr_mode_i = 1'b0;
    wr_addr_i = '0; wr_bit_i = '0; wr_data_i = '0; clear_i = 1'b0;
    t_prev = 0;

    // Reset values, then ready only in writer slots
    repeat (3) @(posedge clk_i);
    #1;
    expect_sig("rst_scr",  SEL_SCR,  0, 0);
    expect_sig("rst_rdy",  SEL_RDY,  0, 0);
    expect_sig("rst_busy", SEL_BUSY, 0, 0);
    expect_sig("rst_done", SEL_DONE, 0, 0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    expect_sig("rdy_ph0a", SEL_RDY, 0, 0);
    @(posedge clk_i); #1;
    expect_sig("rdy_ph1a", SEL_RDY, 1, 0);
    @(posedge clk_i); #1;
    expect_sig("rdy_ph0b", SEL_RDY, 0, 0);
    @(posedge clk_i); #1;
    expect_sig("rdy_ph1b", SEL_RDY, 1, 0);

    // Preload and screen read
    byte_write(10'h000, 8'hA5);
    read_check(10'h000, 8'hA5);

    // Byte write, then back-to-back stream accepted every 2 clocks
    byte_write(10'h005, 8'h3C);
    read_check(10'h005, 8'h3C);
    wr_valid_i = 1'b1; wr_mode_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wr_addr_i = 10'(6 + k);
      wr_data_i = 8'(8'h50 + k);
      wait_accept("b2b_accept", t_acc);
      if (k > 0) expect_sig("b2b_gap", SEL_MEAS, 2, 32'((t_acc - t_prev) / 10));
      t_prev = t_acc;
    end
    wr_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) read_check(10'(6 + k), 8'(8'h50 + k));

    // Pixel read-modify-write
    byte_write(10'h085, 8'h00);
    pixel_op(10'h085, 3'd1, 1'b1, 1'b1, "pix_set");
    read_check(10'h085, 8'h02);
    pixel_op(10'h085, 3'd1, 1'b0, 1'b1, "pix_clr");
    read_check(10'h085, 8'h00);
    byte_write(10'h100, 8'hF0);
    pixel_op(10'h100, 3'd7, 1'b0, 1'b0, "pix_b7");
    read_check(10'h100, 8'h70);
    pixel_op(10'h100, 3'd0, 1'b1, 1'b0, "pix_b0");
    read_check(10'h100, 8'h71);

    // Full clear over an all-FF framebuffer
    fill_bytes(8'hFF);
    read_check(10'h000, 8'hFF);
    read_check(10'h2AA, 8'hFF);
    read_check(10'h3FF, 8'hFF);
    clear_and_measure("clr1");
    for (int a = 0; a < DEPTH; a++) read_check(10'(a), 8'h00);

    // Clear raised during PIX_WR waits for the pixel; a repeat clear is ignored
    pixel_op(10'h200, 3'd3, 1'b1, 1'b0, "pix_mid");
    @(posedge clk_i); #1;
    expect_sig("pixwr_busy", SEL_BUSY, 1, 0);
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    exp_done++;
    expect_sig("pend_rdy",  SEL_RDY,  0, 0);
    expect_sig("pend_busy", SEL_BUSY, 1, 0);
    read_check(10'h200, 8'h08);
    repeat (200) @(posedge clk_i);
    #1;
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    begin
      bit fin;
      fin = 1'b0;
      for (int i = 0; i < 3000 && !fin; i++) begin
        @(negedge clk_i);
        if (!busy_o) fin = 1'b1;
      end
      if (!fin) fail_now("clr2_busy_end");
    end
    @(posedge clk_i); #1;
    expect_sig("clr2_done_cnt", SEL_DCNT, exp_done, 0);
    repeat (100) @(posedge clk_i);
    #1;
    expect_sig("clr2_idle_busy", SEL_BUSY, 0, 0);
    expect_sig("clr2_one_done",  SEL_DCNT, exp_done, 0);
    read_check(10'h200, 8'h00);

    // Reset mid-clear once 300 bytes are cleared: writes of byte k land at
    // E(3+2k) after the sampling edge E0, so byte 299 lands at E601
    fill_bytes(8'hFF);
    align_phase0();
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    repeat (601) @(posedge clk_i);
    #1;
    rst_n_i = 1'b0;
    #1;
    expect_sig("mid_rst_scr",  SEL_SCR,  0, 0);
    expect_sig("mid_rst_rdy",  SEL_RDY,  0, 0);
    expect_sig("mid_rst_busy", SEL_BUSY, 0, 0);
    expect_sig("mid_rst_done", SEL_DONE, 0, 0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    for (int a = 0; a < DEPTH; a++) read_check(10'(a), (a < 300) ? 8'h00 : 8'hFF);
    expect_sig("mid_rst_no_done", SEL_DCNT, exp_done, 0);

    repeat (2) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
